// File: rtl/mod_74x169_n_pkg.sv
// rtl/mod_74x169_n_pkg.sv - shared 74xx constants, counter op encoding, modulus check
package mod_74x169_n_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Active-low control levels
  localparam logic LOW_ASSERTED   = 1'b0;
  localparam logic LOW_DEASSERTED = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_e;

  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 30) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/mod_74x169_n_if.sv
// rtl/mod_74x169_n_if.sv - counter control/data bundle with driver and counter views
interface mod_74x169_n_if #(
  parameter int WIDTH = 4
);
  logic             load_n;
  logic             enp;
  logic             ent;
  logic             up;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (
    output load_n, enp, ent, up, d,
    input  q, rco
  );

  modport slave (
    input  load_n, enp, ent, up, d,
    output q, rco
  );
endinterface

// File: rtl/mod_74x169_n_cnt_next.sv
// rtl/mod_74x169_n_cnt_next.sv - next-count and terminal-count logic for a modulo up/down counter
module mod_74x_cnt_next
  import mod_74x169_n_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // Counting up from an out-of-range value wraps to 0; counting down from one
  // simply decrements, walking back into range.
  always_comb begin
    o_next = i_q;
    o_tc   = 1'b0;
    if (i_up == DIR_UP) begin
      o_tc   = (i_q >= LAST);
      o_next = o_tc ? '0 : i_q + WIDTH'(1);
    end else begin
      o_tc   = (i_q == '0);
      o_next = o_tc ? LAST : i_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_74x169_n.sv
// rtl/mod_74x169_n.sv - N-bit presettable up/down modulo counter with ENP/ENT and ripple carry out
module mod_74x169_n
  import mod_74x169_n_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic                i_clk,
  input  logic                i_clr_n,
  mod_74x169_n_if.slave       io_cnt
);

  generate
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $fatal(1, "mod_74x169_n: MODULUS must lie in [2, 2**WIDTH]");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  op_e              w_op;

  mod_74x_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .i_q    (r_q),
    .i_up   (io_cnt.up),
    .o_next (w_next),
    .o_tc   (w_tc)
  );

  // Load wins over counting regardless of ENP/ENT/UP.
  always_comb begin
    w_op = OP_HOLD;
    if (io_cnt.load_n == LOW_ASSERTED) begin
      w_op = OP_LOAD;
    end else if (io_cnt.enp && io_cnt.ent) begin
      w_op = OP_COUNT;
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_q <= '0;
    end else begin
      case (w_op)
        OP_LOAD:  r_q <= io_cnt.d;
        OP_COUNT: r_q <= w_next;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign io_cnt.q   = r_q;
  assign io_cnt.rco = io_cnt.ent & w_tc;

endmodule
